// File: rtl/if_prefetch_queue_pkg.sv
// Shared types and constants for the instruction prefetch queue.
package if_prefetch_queue_pkg;

    localparam int unsigned AW_DEFAULT    = 32;
    localparam int unsigned DEPTH_DEFAULT = 4;
    localparam int unsigned PC_STEP       = 4;

    // One buffered fetch: address and the word read at that address.
    typedef struct packed {
        logic [AW_DEFAULT-1:0] pc;
        logic [AW_DEFAULT-1:0] instr;
    } entry_t;

endpackage

// File: rtl/if_prefetch_ram.sv
// Entry storage for the prefetch queue: one synchronous write port and one
// asynchronous read port. Contents are not reset.
module if_prefetch_ram #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned W     = 64
) (
    input  logic                     clk,
    input  logic                     we_i,
    input  logic [$clog2(DEPTH)-1:0] waddr_i,
    input  logic [W-1:0]             wdata_i,
    input  logic [$clog2(DEPTH)-1:0] raddr_i,
    output logic [W-1:0]             rdata_o
);

    logic [W-1:0] mem_q [DEPTH];

    // Write the pushed entry at the write pointer.
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/if_prefetch_queue.sv
// Instruction prefetch FIFO between fetch and decode. Freezes fetch while
// full and drops every buffered entry on a taken branch (flush).
// Optional zero-latency bypass when empty: define IF_PREFETCH_BYPASS_EN.
module if_prefetch_queue
    import if_prefetch_queue_pkg::*;
#(
    parameter int unsigned DEPTH = DEPTH_DEFAULT,
    parameter int unsigned AW    = AW_DEFAULT
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    input  logic [AW-1:0]          in_pc,
    input  logic [AW-1:0]          in_instr,
    input  logic                   flush,
    output logic                   fetch_freeze,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [AW-1:0]          out_pc,
    output logic [AW-1:0]          out_pc_plus4,
    output logic [AW-1:0]          out_instr,
    output logic [$clog2(DEPTH):0] count
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;
    localparam int unsigned EW = 2 * AW;

    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          push_c, pop_c, byp_c, nonempty_c;
    logic [EW-1:0] rdata_c;

    assign nonempty_c = (count_q != '0);

`ifdef IF_PREFETCH_BYPASS_EN
    // Empty queue: the incoming word is presented to decode in the same cycle.
    assign byp_c = !nonempty_c && in_valid && !flush;
`else
    assign byp_c = 1'b0;
`endif

    assign fetch_freeze = (count_q == CW'(DEPTH));
    // A bypassed word taken by decode is never written.
    assign push_c = in_valid && !fetch_freeze && !flush && !(byp_c && out_ready);
    assign pop_c  = nonempty_c && out_ready && !flush;

    // Head presentation; reads zero while empty so stale storage never leaks.
    always_comb begin
        out_valid = nonempty_c || byp_c;
        out_pc    = '0;
        out_instr = '0;
        if (byp_c) begin
            out_pc    = in_pc;
            out_instr = in_instr;
        end else if (nonempty_c) begin
            out_pc    = rdata_c[EW-1:AW];
            out_instr = rdata_c[AW-1:0];
        end
    end

    assign out_pc_plus4 = out_pc + AW'(PC_STEP);
    assign count        = count_q;

    // Next pointer/occupancy; flush overrides any push or pop this cycle.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push_c) wr_ptr_d = wr_ptr_q + PW'(1);
            if (pop_c)  rd_ptr_d = rd_ptr_q + PW'(1);
            count_d = count_q + CW'(push_c) - CW'(pop_c);
        end
    end

    // Pointer and occupancy registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    if_prefetch_ram #(
        .DEPTH (DEPTH),
        .W     (EW)
    ) u_ram (
        .clk     (clk),
        .we_i    (push_c),
        .waddr_i (wr_ptr_q),
        .wdata_i ({in_pc, in_instr}),
        .raddr_i (rd_ptr_q),
        .rdata_o (rdata_c)
    );

endmodule

// File: tb/tb_if_prefetch_queue.sv
// Self-checking bench for if_prefetch_queue (DEPTH=4, AW=32).
module tb_if_prefetch_queue;
    import if_prefetch_queue_pkg::*;

    localparam int unsigned DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic [31:0] in_pc;
    logic [31:0] in_instr;
    logic        flush;
    logic        fetch_freeze;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_pc;
    logic [31:0] out_pc_plus4;
    logic [31:0] out_instr;
    logic [2:0]  count;

    int total = 0;
    int bad   = 0;

    entry_t q[$];

    typedef struct {
        logic        v;
        logic [31:0] pc;
        logic        fl;
        logic        rdy;
        logic        ev;
        logic [31:0] epc;
        int          ecnt;
        logic        efz;
    } vec_t;

    vec_t vecs[13];

    if_prefetch_queue #(.DEPTH(DEPTH), .AW(32)) dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_pc        (in_pc),
        .in_instr     (in_instr),
        .flush        (flush),
        .fetch_freeze (fetch_freeze),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_pc       (out_pc),
        .out_pc_plus4 (out_pc_plus4),
        .out_instr    (out_instr),
        .count        (count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // One cycle against the queue model: check current outputs, then update the model.
    task automatic step(input logic v, input logic [31:0] pc, input logic [31:0] ins,
                        input logic fl, input logic rdy);
        int     sz;
        logic   byp, ev, push;
        entry_t head;
        @(negedge clk);
        in_valid = v; in_pc = pc; in_instr = ins; flush = fl; out_ready = rdy;
        #1;
        sz  = q.size();
        byp = 1'b0;
`ifdef IF_PREFETCH_BYPASS_EN
        byp = (sz == 0) && v && !fl;
`endif
        ev   = (sz != 0) || byp;
        head = byp ? entry_t'({pc, ins}) : ((sz != 0) ? q[0] : entry_t'(0));
        chk("count", 32'(count), 32'(sz));
        chk("fetch_freeze", 32'(fetch_freeze), 32'(sz == DEPTH));
        chk("out_valid", 32'(out_valid), 32'(ev));
        chk("out_pc", out_pc, head.pc);
        chk("out_instr", out_instr, head.instr);
        chk("out_pc_plus4", out_pc_plus4, head.pc + 32'd4);
        if (fl) begin
            q.delete();
        end else begin
            push = v && (sz < DEPTH) && !(byp && rdy);
            if (ev && rdy && !byp) void'(q.pop_front());
            if (push) q.push_back({pc, ins});
        end
        @(posedge clk);
    endtask

    task automatic run_vec(input vec_t t);
        @(negedge clk);
        in_valid = t.v; in_pc = t.pc; in_instr = 32'hE000_0000 + t.pc;
        flush = t.fl; out_ready = t.rdy;
        #1;
        chk("tbl_count", 32'(count), 32'(t.ecnt));
        chk("tbl_freeze", 32'(fetch_freeze), 32'(t.efz));
        chk("tbl_valid", 32'(out_valid), 32'(t.ev));
        chk("tbl_pc", out_pc, t.epc);
        if (t.ev) chk("tbl_instr", out_instr, 32'hE000_0000 + t.epc);
        @(posedge clk);
    endtask

    initial begin
        int pushed;
        logic [31:0] pc;

        // Fill/backpressure, fifth word ignored, single pop, flush while full, refill.
        vecs[0]  = '{1'b1, 32'h00,  1'b0, 1'b0, 1'b0, 32'h00,  0, 1'b0};
        vecs[1]  = '{1'b1, 32'h04,  1'b0, 1'b0, 1'b1, 32'h00,  1, 1'b0};
        vecs[2]  = '{1'b1, 32'h08,  1'b0, 1'b0, 1'b1, 32'h00,  2, 1'b0};
        vecs[3]  = '{1'b1, 32'h0C,  1'b0, 1'b0, 1'b1, 32'h00,  3, 1'b0};
        vecs[4]  = '{1'b1, 32'h2C,  1'b0, 1'b0, 1'b1, 32'h00,  4, 1'b1};
        vecs[5]  = '{1'b0, 32'h00,  1'b0, 1'b1, 1'b1, 32'h00,  4, 1'b1};
        vecs[6]  = '{1'b0, 32'h00,  1'b0, 1'b0, 1'b1, 32'h04,  3, 1'b0};
        vecs[7]  = '{1'b1, 32'h10,  1'b0, 1'b0, 1'b1, 32'h04,  3, 1'b0};
        vecs[8]  = '{1'b1, 32'h14,  1'b1, 1'b1, 1'b1, 32'h04,  4, 1'b1};
        vecs[9]  = '{1'b1, 32'h100, 1'b0, 1'b0, 1'b0, 32'h00,  0, 1'b0};
        vecs[10] = '{1'b0, 32'h00,  1'b0, 1'b0, 1'b1, 32'h100, 1, 1'b0};
        vecs[11] = '{1'b0, 32'h00,  1'b0, 1'b1, 1'b1, 32'h100, 1, 1'b0};
        vecs[12] = '{1'b0, 32'h00,  1'b0, 1'b0, 1'b0, 32'h00,  0, 1'b0};

        rst = 1'b1; in_valid = 1'b0; in_pc = '0; in_instr = '0; flush = 1'b0; out_ready = 1'b0;
        #12;
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_freeze", 32'(fetch_freeze), 32'd0);
        chk("rst_pc", out_pc, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // Idle after reset.
        for (int i = 0; i < 5; i++) step(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);

`ifndef IF_PREFETCH_BYPASS_EN
        foreach (vecs[i]) run_vec(vecs[i]);
`endif

        // Streaming with decode always ready.
        for (int i = 0; i < 6; i++) step(1'b1, 32'(4 * i), 32'hE000_0000 + 32'(4 * i), 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) step(1'b0, 32'h0, 32'h0, 1'b0, 1'b1);

        // Wrap-around: 10 entries, alternating decode readiness.
        pushed = 0;
        for (int i = 0; i < 40 && pushed < 10; i++) begin
            int sz0;
            sz0 = q.size();
            step(1'b1, 32'h200 + 32'(4 * pushed), 32'hE000_0200 + 32'(4 * pushed), 1'b0, i[0]);
            if (sz0 < DEPTH) pushed++;
        end
        for (int i = 0; i < 6; i++) step(1'b0, 32'h0, 32'h0, 1'b0, 1'b1);

        // Bypass corner: empty queue, word at 0x40 with decode ready.
        step(1'b1, 32'h40, 32'hE000_0040, 1'b0, 1'b1);
        step(1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
        step(1'b0, 32'h0, 32'h0, 1'b0, 1'b1);

        // Flush from full with push and pop requested, then fresh word.
        for (int i = 0; i < 4; i++) step(1'b1, 32'h10 + 32'(4 * i), 32'hE000_0010 + 32'(4 * i), 1'b0, 1'b0);
        step(1'b1, 32'h20, 32'hE000_0020, 1'b1, 1'b1);
        step(1'b1, 32'h100, 32'hE000_0100, 1'b0, 1'b0);
        step(1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
        step(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);

        // Random traffic with occasional flushes.
        pc = 32'h1000;
        for (int i = 0; i < 80; i++) begin
            step($urandom_range(0, 3) != 0, pc, pc ^ 32'hA5A5_0000,
                 $urandom_range(0, 15) == 0, 1'($urandom_range(0, 1)));
            pc += 32'd4;
        end

        // Asynchronous reset mid-operation.
        step(1'b1, 32'h300, 32'hE000_0300, 1'b0, 1'b0);
        step(1'b1, 32'h304, 32'hE000_0304, 1'b0, 1'b0);
        @(negedge clk);
        in_valid = 1'b0;
        #2 rst = 1'b1;
        #1;
        chk("arst_count", 32'(count), 32'd0);
        chk("arst_valid", 32'(out_valid), 32'd0);
        chk("arst_pc", out_pc, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        q.delete();
        step(1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
        step(1'b1, 32'h400, 32'hE000_0400, 1'b0, 1'b0);
        step(1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
        step(1'b0, 32'h0, 32'h0, 1'b0, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/if_prefetch_queue.md
Name: if_prefetch_queue

Overview:
- Small instruction prefetch FIFO between the fetch stage (PC register + instruction memory) and the decode stage.
- Buffers {fetch address, instruction} pairs so that a decode stall does not immediately freeze fetch.
- Drives the fetch-stage freeze when full.
- Flushes all buffered entries on a taken branch.

Parameters:
- DEPTH, 4, number of entries; power of two, minimum 2.
- AW, 32, address and instruction width.

Ports:
- clk  input  1  clock
- rst  input  1  asynchronous, active-high reset
- in_valid  input  1  fetch stage presents a fetched word this cycle
- in_pc  input  AW  fetch address of in_instr
- in_instr  input  AW  instruction read at in_pc
- flush  input  1  branch taken; discard all entries
- fetch_freeze  output  1  freeze request to the fetch PC register
- out_valid  output  1  head entry valid for decode
- out_ready  input  1  decode accepts head (decode not frozen)
- out_pc  output  AW  head fetch address
- out_pc_plus4  output  AW  out_pc + 4, modulo 2^AW
- out_instr  output  AW  head instruction
- count  output  $clog2(DEPTH)+1  current occupancy

Behaviour:
- Reset (async, rst=1): wr_ptr=0, rd_ptr=0, count=0, out_valid=0, fetch_freeze=0. out_pc/out_instr read 0. Storage contents are not reset.
- push = in_valid && !fetch_freeze && !flush.
- pop = out_valid && out_ready && !flush.
- Pointers are log2(DEPTH) bits and wrap naturally from DEPTH-1 to 0.
- count is updated as count + push - pop.
- fetch_freeze = (count == DEPTH). It is combinational from registered count.
  - No push while full, even if a pop occurs in the same cycle.
  - The fetch stage therefore stalls exactly while full.
- out_valid = (count != 0). out_pc/out_instr come from storage[rd_ptr]. Latency from push to visibility is 1 cycle.
- Empty with pop requested: no pop, because out_valid=0. Pointers and count are unchanged.
- Simultaneous push and pop with 0<count<DEPTH: count unchanged, both pointers advance.
- flush (highest priority): next cycle wr_ptr=rd_ptr=0, count=0, out_valid=0. Any push or pop in the flush cycle is discarded. The fetch stage loads the branch target in the same edge, so the first post-flush word arrives the cycle after.
- flush while full: fetch_freeze drops the cycle after flush.
- rst asserted mid-operation: all state clears immediately. No entry survives.
- Ordering is strict FIFO. Entries are never reordered or duplicated.

Optional Feature:
- Macro: IF_PREFETCH_BYPASS_EN.
- Enabled:
  - When count==0 and in_valid && !flush, in_pc/in_instr drive the out_* ports combinationally and out_valid=1.
  - If out_ready=1 in that cycle, the word is consumed and not written. count stays 0.
  - If out_ready=0, the word is written normally.
  - Zero-latency fetch-to-decode when empty.
- Disabled: behaviour exactly as above, with 1-cycle minimum latency.

Decomposition:
- Shared package holds:
  - the entry typedef {pc[AW-1:0], instr[AW-1:0]};
  - the constant PC_STEP = 4;
  - the default-depth constant.
- One natural sub-module: if_prefetch_ram, a DEPTH×2AW register array with one synchronous write port and one asynchronous read port.
- Pointer, count and handshake logic stay in the top module.

Test Plan:
- Reset then idle: rst pulse, in_valid=0 → count=0, out_valid=0, fetch_freeze=0 for 5 cycles.
- Streaming: in_valid=1 with pc=0,4,8,... and instr=0xE0000000+pc, out_ready=1 → out_pc sequence 0,4,8 one cycle after each push. count stays 1. out_pc_plus4 = out_pc+4.
- Fill/backpressure: out_ready=0, push pc 0x00..0x0C → count=4, fetch_freeze=1. A fifth in_valid is ignored. Then out_ready=1 for one cycle → out_pc=0x00 popped, count=3, freeze=0 next cycle.
- Flush while full: queue full of pc 0x10..0x1C, flush=1 with in_valid=1 and out_ready=1 → next cycle count=0, out_valid=0. Next push pc=0x100 appears as head with no stale entry.
- Wrap-around: push/pop 10 entries through DEPTH=4 with alternating out_ready → output order matches input order exactly and pointers wrap without loss.
- Bypass (with IF_PREFETCH_BYPASS_EN): empty queue, in_valid=1, pc=0x40, out_ready=1 → out_valid=1 and out_pc=0x40 same cycle, count remains 0. Without the macro → out_valid=0 that cycle, then out_pc=0x40 the next.
